// File: rtl/nonce_collector.sv
// rtl/nonce_collector.sv - serial nonce readout, host handshake and hit accounting
//
// Purpose: when the buffer reports a hit, request a serial readout, shift
// 32 bits in LSB-first, then hold the nonce until the host accepts it.
// A single hit arriving while the nonce waits for the host is remembered
// as pending. Any further hit is counted as dropped. A hit that arrives
// during readout is flagged as an error and counted as dropped.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   valid_i           buffer stage valid
//   success_i         buffer stage success, qualified by valid_i
//   nonce_bit_i       serial nonce bit, LSB first, starting in the request cycle
//   buffer_error_i    sticky error from the buffer
//   readready_o       one-cycle readout request
//   nonce_o           assembled nonce
//   nonce_valid_o     nonce_o is complete and awaits nonce_ack_i
//   nonce_ack_i       host accepts nonce_o
//   found_count_o     saturating count of accepted nonces
//   dropped_count_o   saturating count of discarded successes
//   error_o           sticky overlap / buffer error
module nonce_collector #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic               success_i,
  input  logic               nonce_bit_i,
  input  logic               buffer_error_i,
  output logic               readready_o,
  output logic [31:0]        nonce_o,
  output logic               nonce_valid_o,
  input  logic               nonce_ack_i,
  output logic [COUNT_W-1:0] found_count_o,
  output logic [COUNT_W-1:0] dropped_count_o,
  output logic               error_o
);

  typedef enum logic [1:0] {IDLE, REQ, SHIFT, HOLD} state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_t             r_state;
  state_t             w_next;
  logic               r_pending;
  logic [4:0]         r_bit_idx;
  logic [31:0]        r_nonce;
  logic [COUNT_W-1:0] r_found;
  logic [COUNT_W-1:0] r_dropped;
  logic               r_error;

  logic w_hit;
  logic w_handshake;
  logic w_overlap;
  logic w_drop;

  assign w_hit       = valid_i & success_i;
  assign w_handshake = (r_state == HOLD) & nonce_ack_i;
  // The buffer is being overwritten while we are still reading it out.
  assign w_overlap   = w_hit & ((r_state == REQ) | (r_state == SHIFT));
  assign w_drop      = w_overlap | (w_hit & (r_state == HOLD) & r_pending);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    readready_o   = 1'b0;
    nonce_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          w_next = REQ;
        end
      end
      REQ: begin
        readready_o = 1'b1;
        w_next      = SHIFT;
      end
      SHIFT: begin
        if (r_bit_idx == 5'd31) begin
          w_next = HOLD;
        end
      end
      HOLD: begin
        nonce_valid_o = 1'b1;
        // A hit coinciding with the handshake counts as a hit in HOLD;
        // either way another readout follows immediately.
        if (w_handshake) begin
          w_next = (r_pending | w_hit) ? REQ : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_bit_idx <= 5'd0;
      r_nonce   <= 32'h0;
      r_found   <= '0;
      r_dropped <= '0;
      r_error   <= 1'b0;
    end else begin
      if (r_state == REQ) begin
        r_nonce[0] <= nonce_bit_i;
        r_bit_idx  <= 5'd1;
      end else if (r_state == SHIFT) begin
        r_nonce[r_bit_idx] <= nonce_bit_i;
        r_bit_idx          <= r_bit_idx + 5'd1;
      end

      if (r_state == HOLD) begin
        if (w_handshake) begin
          r_pending <= 1'b0;
        end else if (w_hit && !r_pending) begin
          r_pending <= 1'b1;
        end
      end

      if (w_handshake && r_found != CNT_MAX) begin
        r_found <= r_found + 1'b1;
      end
      if (w_drop && r_dropped != CNT_MAX) begin
        r_dropped <= r_dropped + 1'b1;
      end

      r_error <= r_error | buffer_error_i | w_overlap;
    end
  end

  assign nonce_o         = r_nonce;
  assign found_count_o   = r_found;
  assign dropped_count_o = r_dropped;
  assign error_o         = r_error;

endmodule

// File: tb/tb_nonce_collector.sv
// tb/tb_nonce_collector.sv - scoreboard bench for nonce_collector
module tb_nonce_collector;

  logic clk = 1'b0;
  logic rst, valid_i, success_i, nonce_bit_i, buffer_error_i, nonce_ack_i;

  logic        a_rr, a_nv, a_err;
  logic [31:0] a_nonce;
  logic [15:0] a_found, a_dropped;

  logic        b_rr, b_nv, b_err;
  logic [31:0] b_nonce;
  logic [1:0]  b_found, b_dropped;

  nonce_collector #(.COUNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .success_i(success_i),
    .nonce_bit_i(nonce_bit_i), .buffer_error_i(buffer_error_i),
    .readready_o(a_rr), .nonce_o(a_nonce), .nonce_valid_o(a_nv),
    .nonce_ack_i(nonce_ack_i), .found_count_o(a_found),
    .dropped_count_o(a_dropped), .error_o(a_err)
  );

  nonce_collector #(.COUNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .valid_i(valid_i), .success_i(success_i),
    .nonce_bit_i(nonce_bit_i), .buffer_error_i(buffer_error_i),
    .readready_o(b_rr), .nonce_o(b_nonce), .nonce_valid_o(b_nv),
    .nonce_ack_i(nonce_ack_i), .found_count_o(b_found),
    .dropped_count_o(b_dropped), .error_o(b_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: readout described by its start cycle, plus host-side flags.
  int          m_start = -1;
  bit          m_hold = 0, m_pending = 0, m_err = 0;
  int          m_found = 0, m_dropped = 0;
  logic [31:0] m_word = 32'h0, buf_word = 32'h0;
  bit          checking = 0;
  bit          chk_zero = 0;

  typedef struct {
    logic [31:0] word;
    int          vcyc;
  } exp_t;
  exp_t sbq[$];
  bit   seen = 0;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic start_read();
    m_start = cyc + 1;
    m_word  = buf_word;
    sbq.push_back('{buf_word, cyc + 33});
  endtask

  task automatic step(input bit hit, input bit ack, input bit r, input bit berr,
                      input logic [31:0] w, input bit pv);
    int pos;
    bit reading;
    @(negedge clk);
    pos     = cyc - m_start;
    reading = (m_start >= 0) && (pos >= 0) && (pos <= 31);
    if (checking) begin
      chk("readready", a_rr, reading && pos == 0);
      chk("readready_sat", b_rr, reading && pos == 0);
      chk("nonce_valid", a_nv, m_hold);
      chk("nonce_valid_sat", b_nv, m_hold);
      chk("found", a_found, sat(m_found, 65535));
      chk("found_sat", b_found, sat(m_found, 3));
      chk("dropped", a_dropped, sat(m_dropped, 65535));
      chk("dropped_sat", b_dropped, sat(m_dropped, 3));
      chk("error", a_err, m_err);
      chk("error_sat", b_err, m_err);
    end
    if (chk_zero) begin
      chk("nonce_reset", a_nonce, 0);
      chk("nonce_reset_sat", b_nonce, 0);
      chk_zero = 0;
    end
    rst            = r;
    valid_i        = hit | pv;
    success_i      = hit ? 1'b1 : (pv ? 1'b0 : 1'($urandom % 2));
    nonce_ack_i    = ack;
    buffer_error_i = berr;
    nonce_bit_i    = reading ? m_word[pos] : 1'($urandom % 2);
    #2;
    if (r) begin
      m_start = -1; m_hold = 0; m_pending = 0;
      m_found = 0; m_dropped = 0; m_err = 0;
      sbq.delete(); seen = 0; checking = 1;
    end else begin
      if (berr) m_err = 1;
      if (hit) buf_word = w;
      if (reading) begin
        if (hit) begin
          m_err = 1;
          m_dropped++;
        end
        if (pos == 31) begin
          m_hold  = 1;
          m_start = -1;
        end
      end else if (m_hold) begin
        if (hit) begin
          if (m_pending) m_dropped++;
          else m_pending = 1;
        end
        if (ack) begin
          m_found++;
          m_hold = 0;
          if (m_pending) begin
            m_pending = 0;
            start_read();
          end
        end
      end else if (hit && m_start < 0) begin
        start_read();
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic hit_w(input logic [31:0] w);
    step(1, 0, 0, 0, w, 0);
  endtask

  task automatic ack1();
    step(0, 1, 0, 0, 32'h0, 0);
  endtask

  task automatic wait_hold();
    int k = 0;
    while (!m_hold && k < 100) begin
      idle(1);
      k++;
    end
    chk("hold_reached", m_hold, 1);
  endtask

  task automatic wait_pos(input int p);
    int k = 0;
    while (!(m_start >= 0 && (cyc + 1 - m_start) == p) && k < 100) begin
      idle(1);
      k++;
    end
    chk("pos_reached", k < 100, 1);
  endtask

  // Monitor: checks each presented nonce against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (checking && a_nv) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL nonce_unexpected: got valid want none at cycle %0d", cyc);
        end else begin
          if (!seen) begin
            chk("valid_cycle", cyc, sbq[0].vcyc);
            seen = 1;
          end
          chk("nonce", a_nonce, sbq[0].word);
          chk("nonce_sat", b_nonce, sbq[0].word);
          if (nonce_ack_i) begin
            void'(sbq.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; valid_i = 1'b0; success_i = 1'b0; nonce_bit_i = 1'b0;
    buffer_error_i = 1'b0; nonce_ack_i = 1'b0;

    step(1, 0, 1, 0, 32'h0, 0);
    step(1, 0, 1, 0, 32'h0, 0);
    chk_zero = 1;
    idle(3);

    // single capture
    hit_w(32'hDEADBEEF);
    wait_hold();
    ack1();
    idle(2);

    // back-pressure with a pending hit
    hit_w(32'h00000001);
    wait_hold();
    idle(4);
    hit_w(32'h80000000);
    idle(5);
    ack1();
    wait_hold();
    ack1();
    idle(2);

    // drop: two extra hits while holding
    hit_w($urandom);
    wait_hold();
    hit_w($urandom);
    hit_w($urandom);
    ack1();
    wait_hold();
    ack1();
    idle(2);

    // valid without success, success without valid
    step(0, 0, 0, 0, 32'h0, 1);
    idle(3);

    // overlap at bit index 10
    hit_w(32'h12345678);
    wait_pos(10);
    hit_w(32'hFFFFFFFF);
    wait_hold();
    ack1();
    idle(2);

    // reset mid-readout, then a fresh capture on the first cycle after reset
    hit_w(32'hCAFEF00D);
    wait_pos(20);
    step(0, 0, 1, 0, 32'h0, 0);
    chk_zero = 1;
    hit_w(32'hDEADBEEF);
    wait_hold();
    ack1();

    // five handshakes for saturation of the narrow counters
    repeat (5) begin
      hit_w($urandom);
      wait_hold();
      ack1();
    end
    step(0, 0, 0, 1, 32'h0, 0);
    idle(5);

    // randomized traffic
    step(0, 0, 1, 0, 32'h0, 0);
    repeat (3000) begin
      step(($urandom % 6) == 0, ($urandom % 3) == 0, ($urandom % 900) == 0,
           ($urandom % 1500) == 0, $urandom, ($urandom % 8) == 0);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nonce_collector.md
NONCE_COLLECTOR -- requirements
Module: nonce_collector

Interface
REQ-001 Parameter: COUNT_W, 16, width of found_count_o and dropped_count_o.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 valid_i  input  1  registered valid from the nonce buffer stage.
REQ-005 success_i  input  1  registered success from the nonce buffer stage; meaningful only when valid_i=1.
REQ-006 nonce_bit_i  input  1  serial nonce bit from the buffer.
REQ-007 buffer_error_i  input  1  sticky error flag from the buffer.
REQ-008 readready_o  output  1  one-cycle request to the buffer to start serial readout.
REQ-009 nonce_o  output  32  assembled nonce.
REQ-010 nonce_valid_o  output  1  nonce_o holds a complete nonce awaiting host acceptance.
REQ-011 nonce_ack_i  input  1  host accepts nonce_o; only meaningful while nonce_valid_o=1.
REQ-012 found_count_o  output  COUNT_W  number of nonces accepted by the host.
REQ-013 dropped_count_o  output  COUNT_W  number of successes discarded.
REQ-014 error_o  output  1  sticky error: overlap or buffer error.

Function
REQ-015 A "hit" SHALL be a cycle with valid_i=1 and success_i=1.
REQ-016 The block SHALL use states IDLE, REQ, SHIFT and HOLD.
REQ-017 IDLE: on a hit, the next state SHALL be REQ; otherwise the state SHALL remain IDLE.
REQ-018 REQ SHALL last exactly one cycle, with readready_o=1; readready_o SHALL be 0 in every other state.
REQ-019 In the REQ cycle, nonce_bit_i SHALL be captured as nonce_o bit 0.
REQ-020 SHIFT SHALL last 31 cycles; in the k-th SHIFT cycle (k=1..31), nonce_bit_i SHALL be captured as nonce_o bit k.
REQ-021 A 5-bit counter SHALL track the bit index; it SHALL load 1 on entering SHIFT and leave SHIFT after index 31 is captured.
REQ-022 HOLD SHALL assert nonce_valid_o=1 and keep nonce_o stable until the handshake.
- Handshake: nonce_valid_o=1 and nonce_ack_i=1 in the same cycle.
- On the handshake, nonce_valid_o SHALL drop on the next cycle.
REQ-023 Total latency from a hit in IDLE to nonce_valid_o=1 SHALL be 33 cycles: 1 cycle to REQ, 1 REQ cycle, 31 SHIFT cycles.
REQ-024 nonce_o SHALL be undefined-but-stable outside HOLD; the bench SHALL check it only while nonce_valid_o=1.
REQ-025 Handshake in HOLD:
- pending=0: next state SHALL be IDLE.
- pending=1: next state SHALL be REQ and pending SHALL clear.
REQ-026 Pending flag (one deep):
- A hit in HOLD with pending=0 SHALL set pending.
- A hit in HOLD with pending=1 SHALL increment dropped_count_o.
REQ-027 A hit in the same cycle as the handshake SHALL be treated as a hit in HOLD before the transition; with pending=0, the next state SHALL be REQ.
REQ-028 A hit during REQ or SHIFT (the buffer is overwritten mid-read) SHALL:
- set error_o and increment dropped_count_o;
- let the readout complete unchanged.
REQ-029 found_count_o SHALL increment by 1 on each handshake.
REQ-030 Both counters SHALL saturate at 2^COUNT_W-1 without wrapping.
REQ-031 error_o SHALL be set one cycle after buffer_error_i=1 is sampled.
REQ-032 Once set, error_o SHALL remain 1 until reset and SHALL NOT alter the state machine.
REQ-033 A hit with valid_i=1, success_i=0 SHALL have no effect; success_i with valid_i=0 SHALL be ignored.

Reset
REQ-034 While rst=1 on a clock edge, the next state SHALL be IDLE, irrespective of current state, including mid-SHIFT or HOLD.
REQ-035 Reset SHALL produce:
- pending=0, bit counter=0;
- readready_o=0, nonce_valid_o=0, error_o=0;
- found_count_o=0, dropped_count_o=0;
- nonce_o=32'h0.
REQ-036 A hit sampled in the same cycle as rst=1 SHALL be ignored.

Verification
REQ-037 Single capture: hit in IDLE, buffer model presents 32'hDEADBEEF LSB-first from the REQ cycle -> readready_o pulses 1 cycle, nonce_valid_o=1 with nonce_o=32'hDEADBEEF exactly 33 cycles after the hit; ack -> found_count_o=1, state IDLE.
REQ-038 Back-pressure plus pending: capture 32'h00000001, hold ack low 10 cycles, second hit (nonce 32'h80000000) during HOLD -> after ack, readready_o pulses the next cycle, second nonce delivered; found_count_o=2, dropped_count_o=0.
REQ-039 Drop: in HOLD, two further hits with ack low -> dropped_count_o=1; after two acks, found_count_o=2.
REQ-040 Overlap: hit at SHIFT bit index 10 -> error_o=1 next cycle, dropped_count_o=1, readout completes, nonce_valid_o asserted at the normal cycle.
REQ-041 Reset mid-operation: rst=1 at SHIFT index 20 -> next cycle all outputs at reset values; a fresh hit then yields a correct nonce in 33 cycles.
REQ-042 Saturation and error: COUNT_W=2, five handshakes -> found_count_o=3; buffer_error_i pulsed 1 cycle -> error_o=1 and stays 1 until rst.
